cordic_vec: RTL and testbench
=============================

# cordic_vec

Pipelined CORDIC vectoring unit: converts one signed 16-bit (sin, cos) sample pair back into a 32-bit phase word and a 16-bit magnitude. It is the inverse of the phase_acc → cordic rotation path, and its phase output uses the same units as phase_acc: 2^32 LSB = one full turn, unsigned, wrapping. It is used for loopback self-check of the NCO lanes and as the phase detector for received I/Q. One instance serves one lane; four instances cover the 4-lane NCO.

## Interface
- ITER, 16: number of CORDIC micro-rotation stages, 8..16.
- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- valid_i  in  1  input sample strobe; one pair per cycle when high.
- sin_i  in  16  signed Q1.15 quadrature (Y) input.
- cos_i  in  16  signed Q1.15 in-phase (X) input.
- phase_o  out  32  atan2(sin_i, cos_i) in turns·2^32, unsigned.
- mag_o  out  16  unsigned magnitude, same scale as the inputs.
- valid_o  out  1  high for one cycle per result, in input order.

## Operation
- Datapath widths: X and Y are sign-extended to 18 bits at entry, so -32768 negates without overflow and CORDIC gain growth fits. Z is 32 bits and wraps modulo 2^32.
- Stage P (pre-rotation):
  - If cos_i < 0: X = -cos, Y = -sin, Z = 0x80000000.
  - Otherwise: X = cos, Y = sin, Z = 0.
  - Result: X ≥ 0 and the residual angle is within ±90°.
- Stages i = 0..ITER-1:
  - If Y ≥ 0: X += Y>>>i; Y -= X>>>i; Z += A[i].
  - Else: X -= Y>>>i; Y += X>>>i; Z -= A[i].
  - Both updates use the pre-stage X and Y values. Shifts are arithmetic.
- Angle table: A[i] = round(atan(2^-i)/(2π)·2^32), held as constants. A[0] = 0x20000000, A[1] = 0x12E4051E, A[2] = 0x09FB385B, A[3] = 0x051111D4.
- Stage O (output):
  - phase_o = Z.
  - mag_o = (X_final · 19898) >> 15, truncated. 19898 = round(0.607253·2^15), which removes the CORDIC gain.
  - Maximum mag_o is ≈ 46341, so it fits in 16 bits unsigned.
- Zero input: a zero flag is set when sin_i = cos_i = 0 and travels with the sample. When set, phase_o = 0 and mag_o = 0.
- Valid handling: valid_i is carried through a shift register of length ITER+2 in step with the data. There is no backpressure; full throughput is one sample per cycle.
- Samples with valid_i low still propagate, but their results never assert valid_o.

## Timing
- Latency: ITER+2 cycles (18 at default), from the clock edge that samples valid_i to the cycle in which valid_o is high with the matching result.
- Throughput: back-to-back valid_i on consecutive cycles yields valid_o on consecutive cycles, with no bubbles and no reordering.
- phase_o and mag_o hold their last value while valid_o is low.
- Reset values, forced immediately and asynchronously when rst_i goes low:
  - valid_o = 0, phase_o = 0, mag_o = 0.
  - The valid shift register and all pipeline registers are cleared.
- Reset mid-operation: every in-flight sample is discarded, and no valid_o is produced for samples accepted before reset.
- After rst_i releases, the first valid_o can appear no earlier than ITER+2 cycles after the first valid_i.
- Accuracy (ITER = 16):
  - |phase error| ≤ 2^16 LSB (≈0.0055°).
  - |mag error| ≤ 4 LSB for inputs with magnitude ≥ 1024.
- Wrap: phase results just below 0 are reported near 0xFFFFFFFF, never as negative values.

## Test plan
- Quadrant points (each is one valid_i pulse): the result appears at cycle +18 with valid_o high for exactly one cycle.
  - (sin, cos) = (0, 32767) → phase_o ≈ 0x00000000, mag_o ≈ 32767.
  - (32767, 0) → 0x40000000.
  - (0, -32767) → 0x80000000.
  - (-32767, 0) → 0xC0000000.
- Extremes: (-32768, -32768) → phase_o ≈ 0xA0000000, mag_o ≈ 46341, no overflow. (0, 0) → phase_o = 0, mag_o = 0.
- Loopback: phase_acc with p_inc = 0x15555555 drives cordic, whose outputs drive cordic_vec.
  - Consecutive phase_o differences equal 0x15555555 ±2^17.
  - mag_o is constant within ±4 LSB.
- Throughput: 100 consecutive valid_i samples of random angles → 100 consecutive valid_o results, in order, each within the accuracy bound of a double-precision atan2 reference.
- Mid-stream reset: stream continuously, then pull rst_i low for 1 cycle in the middle of an output burst.
  - valid_o, phase_o and mag_o go to 0 immediately.
  - No stale results appear after release.
  - The first new result arrives 18 cycles after the first new valid_i.
- Gapped input: valid_i is toggled in the pattern 1,0,0,1,1,0 → valid_o reproduces 1,0,0,1,1,0 delayed by exactly 18 cycles, and the outputs hold their value during the gaps.

Source files
------------

// File: rtl/cordic_vec.sv
// Pipelined CORDIC vectoring unit: (sin, cos) -> phase (turns * 2^32) and magnitude.
// One pre-rotation stage, ITER micro-rotation stages and one output stage.
module cordic_vec #(
  parameter int unsigned ITER = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [15:0] sin_i,
  input  logic [15:0] cos_i,
  output logic [31:0] phase_o,
  output logic [15:0] mag_o,
  output logic        valid_o
);

  localparam int N = int'(ITER);
  localparam logic [15:0] INV_GAIN = 16'd19898;

  function automatic logic [31:0] atan_lut(input int i);
    case (i)
      0:       atan_lut = 32'h2000_0000;
      1:       atan_lut = 32'h12E4_051E;
      2:       atan_lut = 32'h09FB_385B;
      3:       atan_lut = 32'h0511_11D4;
      4:       atan_lut = 32'h028B_0D43;
      5:       atan_lut = 32'h0145_D7E1;
      6:       atan_lut = 32'h00A2_F61E;
      7:       atan_lut = 32'h0051_7C55;
      8:       atan_lut = 32'h0028_BE53;
      9:       atan_lut = 32'h0014_5F2F;
      10:      atan_lut = 32'h000A_2F98;
      11:      atan_lut = 32'h0005_17CC;
      12:      atan_lut = 32'h0002_8BE6;
      13:      atan_lut = 32'h0001_45F3;
      14:      atan_lut = 32'h0000_A2FA;
      15:      atan_lut = 32'h0000_517D;
      default: atan_lut = 32'h0000_0000;
    endcase
  endfunction

  // Index 0 holds the pre-rotated sample, index i+1 the result of micro-rotation i.
  logic signed [17:0] x_q [N+1];
  logic signed [17:0] y_q [N+1];
  logic [31:0]        z_q [N+1];
  logic [N:0]         zero_q;
  logic [N:0]         vld_q;

  logic signed [17:0] sin_x, cos_x, x_p, y_p;
  logic [31:0]        z_p;
  logic               zero_p;
  logic [31:0]        mag_prod;

  always_comb begin
    sin_x  = {{2{sin_i[15]}}, sin_i};
    cos_x  = {{2{cos_i[15]}}, cos_i};
    zero_p = (sin_i == 16'd0) && (cos_i == 16'd0);
    // Fold the left half-plane onto the right so the residual angle is within +/-90 degrees.
    if (cos_i[15]) begin
      x_p = -cos_x;
      y_p = -sin_x;
      z_p = 32'h8000_0000;
    end else begin
      x_p = cos_x;
      y_p = sin_x;
      z_p = 32'h0000_0000;
    end
  end

  // X is non-negative after pre-rotation and only grows, so 17 bits carry its magnitude.
  assign mag_prod = {15'd0, x_q[N][16:0]} * {16'd0, INV_GAIN};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i <= N; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
      end
      zero_q  <= '0;
      vld_q   <= '0;
      phase_o <= '0;
      mag_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      x_q[0]    <= x_p;
      y_q[0]    <= y_p;
      z_q[0]    <= z_p;
      zero_q[0] <= zero_p;
      vld_q[0]  <= valid_i;
      for (int i = 0; i < N; i++) begin
        if (!y_q[i][17]) begin
          x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
          z_q[i+1] <= z_q[i] + atan_lut(i);
        end else begin
          x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
          z_q[i+1] <= z_q[i] - atan_lut(i);
        end
        zero_q[i+1] <= zero_q[i];
        vld_q[i+1]  <= vld_q[i];
      end
      valid_o <= vld_q[N];
      // Outputs only move for valid samples so they hold across gaps.
      if (vld_q[N]) begin
        phase_o <= zero_q[N] ? 32'd0 : z_q[N];
        mag_o   <= zero_q[N] ? 16'd0 : 16'(mag_prod >> 15);
      end
    end
  end

endmodule

// File: tb/tb_cordic_vec.sv
// Bench for cordic_vec: vector table, random stream, loopback, gapped input and mid-stream reset,
// all checked through an in-order scoreboard against a double-precision atan2 model.
module tb_cordic_vec;

  localparam int LAT = 18;
  localparam real PI = 3.14159265358979323846;
  localparam real TWO32 = 4294967296.0;
  localparam longint PH_TOL = 65536;
  localparam longint MAG_TOL = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [15:0] sin_i = '0;
  logic [15:0] cos_i = '0;
  logic [31:0] phase_o;
  logic [15:0] mag_o;
  logic        valid_o;

  cordic_vec #(.ITER(16)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .sin_i   (sin_i),
    .cos_i   (cos_i),
    .phase_o (phase_o),
    .mag_o   (mag_o),
    .valid_o (valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] ph;
    int          mag;
    bit          exact;
    int          cyc;
    bit          lb;
  } exp_t;

  typedef struct {
    int          s;
    int          c;
    logic [31:0] ph;
    int          mag;
  } vec_t;

  exp_t        sb_q[$];
  logic [31:0] lb_ph[$];
  int          lb_mag[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] last_ph = '0;
  logic [15:0] last_mag = '0;
  exp_t        e;

  always @(posedge clk_i) cyc++;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_ph(input int s, input int c);
    real    a;
    longint l;
    a = $atan2(real'(s), real'(c)) / (2.0 * PI) * TWO32;
    if (a < 0.0) a = a + TWO32;
    l = longint'(a);
    return l[31:0];
  endfunction

  function automatic int model_mag(input int s, input int c);
    return int'($sqrt(real'(s) * real'(s) + real'(c) * real'(c)));
  endfunction

  task automatic push(input int s, input int c, input logic [31:0] ph, input int mag,
                      input bit lb);
    sb_q.push_back('{ph: ph, mag: mag, exact: (s == 0 && c == 0), cyc: cyc, lb: lb});
  endtask

  task automatic drive(input int s, input int c, input bit v, input bit lb);
    @(negedge clk_i);
    sin_i   = 16'(s);
    cos_i   = 16'(c);
    valid_i = v;
    if (v) push(s, c, model_ph(s, c), model_mag(s, c), lb);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(int'($urandom_range(0, 65535)) - 32768, 1000, 1'b0, 1'b0);
  endtask

  task automatic drive_angle(input logic [31:0] ang, input bit lb);
    real r;
    r = real'(ang) / TWO32 * 2.0 * PI;
    drive(int'(30000.0 * $sin(r)), int'(30000.0 * $cos(r)), 1'b1, lb);
  endtask

  // Scoreboard: every valid_o pops the oldest expectation; gaps must hold the last result.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      last_ph  = '0;
      last_mag = '0;
    end else if (valid_o) begin
      if (sb_q.size() == 0) begin
        chk(1'b0, "unexpected_valid", 1, 0);
      end else begin
        longint pd, md;
        e  = sb_q.pop_front();
        pd = longint'(int'(phase_o - e.ph));
        md = longint'(mag_o) - longint'(e.mag);
        chk(cyc == e.cyc + LAT, "latency", cyc - e.cyc, LAT);
        if (e.exact) begin
          chk(phase_o == 32'd0, "zero_phase", phase_o, 0);
          chk(mag_o == 16'd0, "zero_mag", mag_o, 0);
        end else begin
          chk(pd <= PH_TOL && pd >= -PH_TOL, "phase", phase_o, e.ph);
          chk(md <= MAG_TOL && md >= -MAG_TOL, "mag", mag_o, e.mag);
        end
        if (e.lb) begin
          lb_ph.push_back(phase_o);
          lb_mag.push_back(int'(mag_o));
        end
      end
      last_ph  = phase_o;
      last_mag = mag_o;
    end else begin
      chk(phase_o == last_ph, "hold_phase", phase_o, last_ph);
      chk(mag_o == last_mag, "hold_mag", mag_o, last_mag);
    end
  end

  vec_t vt[9];
  bit   gap_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    vt[0] = '{s: 0,      c: 32767,  ph: 32'h0000_0000, mag: 32767};
    vt[1] = '{s: 32767,  c: 0,      ph: 32'h4000_0000, mag: 32767};
    vt[2] = '{s: 0,      c: -32767, ph: 32'h8000_0000, mag: 32767};
    vt[3] = '{s: -32767, c: 0,      ph: 32'hC000_0000, mag: 32767};
    vt[4] = '{s: -32768, c: -32768, ph: 32'hA000_0000, mag: 46341};
    vt[5] = '{s: 0,      c: 0,      ph: 32'h0000_0000, mag: 0};
    vt[6] = '{s: 30000,  c: 30000,  ph: 32'h2000_0000, mag: 42426};
    vt[7] = '{s: -20000, c: 20000,  ph: 32'hE000_0000, mag: 28284};
    vt[8] = '{s: 0,      c: -32768, ph: 32'h8000_0000, mag: 32768};

    #2 rst_i = 1'b0;
    #1;
    chk(valid_o == 1'b0, "reset_valid", valid_o, 0);
    chk(phase_o == 32'd0, "reset_phase", phase_o, 0);
    chk(mag_o == 16'd0, "reset_mag", mag_o, 0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;

    // Table points, each a single pulse with idle cycles between.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      sin_i   = 16'(vt[i].s);
      cos_i   = 16'(vt[i].c);
      valid_i = 1'b1;
      push(vt[i].s, vt[i].c, vt[i].ph, vt[i].mag, 1'b0);
      idle(2);
    end
    // Just below zero must wrap to the top of the range.
    drive(-100, 32767, 1'b1, 1'b0);
    idle(LAT + 4);

    // Back-to-back random angles.
    for (int i = 0; i < 100; i++) drive_angle($urandom, 1'b0);
    idle(LAT + 4);

    // Loopback of a phase accumulator stepping by 0x15555555.
    begin
      logic [31:0] ang = 32'h0;
      for (int i = 0; i < 24; i++) begin
        drive_angle(ang, 1'b1);
        ang = ang + 32'h1555_5555;
      end
    end
    idle(LAT + 4);
    chk(lb_ph.size() == 24, "loopback_count", lb_ph.size(), 24);
    begin
      longint sum = 0;
      int     mean;
      for (int i = 1; i < lb_ph.size(); i++) begin
        longint d;
        d = longint'(int'(lb_ph[i] - lb_ph[i-1] - 32'h1555_5555));
        chk(d <= 131072 && d >= -131072, "loopback_step", lb_ph[i] - lb_ph[i-1], 32'h1555_5555);
      end
      foreach (lb_mag[i]) sum += lb_mag[i];
      mean = (lb_mag.size() > 0) ? int'(sum / lb_mag.size()) : 0;
      foreach (lb_mag[i])
        chk(lb_mag[i] - mean <= 4 && mean - lb_mag[i] <= 4, "loopback_mag", lb_mag[i], mean);
    end

    // Gapped input 1,0,0,1,1,0; the monitor checks latency and holding during gaps.
    for (int i = 0; i < 6; i++) begin
      if (gap_pat[i]) drive_angle($urandom, 1'b0);
      else idle(1);
    end
    idle(LAT + 4);

    // Mid-stream reset during an output burst.
    for (int i = 0; i < 24; i++) drive_angle($urandom, 1'b0);
    @(posedge clk_i);
    #2;
    valid_i = 1'b0;
    rst_i   = 1'b0;
    #1;
    chk(valid_o == 1'b0, "midreset_valid", valid_o, 0);
    chk(phase_o == 32'd0, "midreset_phase", phase_o, 0);
    chk(mag_o == 16'd0, "midreset_mag", mag_o, 0);
    sb_q.delete();
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    idle(LAT + 10);
    drive_angle(32'h3000_0000, 1'b0);
    idle(LAT + 4);

    chk(sb_q.size() == 0, "pending_results", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: actual=%0d required=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
